// File: rtl/bp_pkg.sv
// bp_pkg: shared BTB entry type, counter constants and saturating helpers
package bp_pkg;
  localparam int TAG_MAX = 32;
  localparam int CTR_MAX = 8;
  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
    logic               jump;
    logic [CTR_MAX-1:0] ctr;
  } btb_entry_t;
  function automatic logic [CTR_MAX-1:0] ctr_weak_t(input int w);
    return CTR_MAX'(1 << (w - 1));
  endfunction
  function automatic logic [CTR_MAX-1:0] ctr_weak_nt(input int w);
    return CTR_MAX'((1 << (w - 1)) - 1);
  endfunction
  function automatic logic [CTR_MAX-1:0] sat_inc(input logic [CTR_MAX-1:0] c, input int w);
    return (c == CTR_MAX'((1 << w) - 1)) ? c : c + 1'b1;
  endfunction
  function automatic logic [CTR_MAX-1:0] sat_dec(input logic [CTR_MAX-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction
endpackage

// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch lookup and execute resolution signals
interface branch_predict_unit_if #(parameter int PC_W = 9);
  logic [PC_W-1:0]    if_pc;
  logic               pred_taken;
  logic [31:0]        pred_target;
  logic               ex_valid;
  logic [PC_W-1:0]    ex_pc;
  logic signed [31:0] ex_imm;
  logic               ex_branch;
  logic               ex_jal;
  logic               ex_jalr;
  logic [31:0]        ex_alu_result;
  logic               ex_pred_taken;
  logic [31:0]        ex_pred_target;
  logic [31:0]        pc_four;
  logic [31:0]        pc_imm;
  logic [31:0]        br_pc;
  logic               pc_sel;
  logic               mispredict;
  logic [31:0]        redirect_pc;
  logic [15:0]        br_count;
  logic [15:0]        mp_count;
  modport master (
    output if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jal, ex_jalr,
           ex_alu_result, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, pc_four, pc_imm, br_pc, pc_sel,
           mispredict, redirect_pc, br_count, mp_count
  );
  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jal, ex_jalr,
           ex_alu_result, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, pc_four, pc_imm, br_pc, pc_sel,
           mispredict, redirect_pc, br_count, mp_count
  );
endinterface

// File: rtl/btb_table.sv
// btb_table: BTB register array with two read ports and one write port
module btb_table import bp_pkg::*; #(
  parameter int ENTRIES = 16,
  parameter int CTR_W = 2,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] ra,
  input  logic [IDX_W-1:0] rb,
  output btb_entry_t       qa,
  output btb_entry_t       qb,
  input  logic             we,
  input  logic [IDX_W-1:0] wa,
  input  btb_entry_t       wd
);
  btb_entry_t mem [ENTRIES];
  assign qa = mem[ra];
  assign qb = mem[rb];
  // reset invalidates every entry and parks counters at weakly not-taken
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, jump: 1'b0, ctr: ctr_weak_nt(CTR_W)};
    end else if (we) begin
      mem[wa] <= wd;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: branch resolver, BTB predictor, training and statistics
module branch_predict_unit import bp_pkg::*; #(
  parameter int PC_W = 9,
  parameter int ENTRIES = 16,
  parameter int CTR_W = 2
) (
  input logic clk,
  input logic reset,
  branch_predict_unit_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int SH = IDX_W + 2;
  logic [31:0] if_pc32, ex_pc32, if_tag, ex_tag, pc_imm, br_pc;
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic taken, hit_if, hit_ex, train, we, unused_lo;
  btb_entry_t if_e, ex_e, wd;
  assign if_pc32 = 32'(bp.if_pc[PC_W-1:0]);
  assign ex_pc32 = 32'(bp.ex_pc[PC_W-1:0]);
  assign if_idx = if_pc32[SH-1:2];
  assign ex_idx = ex_pc32[SH-1:2];
  assign if_tag = if_pc32 >> SH;
  assign ex_tag = ex_pc32 >> SH;
  assign unused_lo = ^if_pc32[1:0];
  btb_table #(.ENTRIES(ENTRIES), .CTR_W(CTR_W)) u_tbl (
    .clk(clk), .reset(reset), .ra(if_idx), .rb(ex_idx), .qa(if_e), .qb(ex_e),
    .we(we), .wa(ex_idx), .wd(wd)
  );
  // resolve the execute-stage instruction and decide whether fetch must be redirected
  always_comb begin
    pc_imm = ex_pc32 + 32'(bp.ex_imm <<< 1);
    taken = (bp.ex_branch && bp.ex_alu_result == 32'd1) || bp.ex_jal || bp.ex_jalr;
    br_pc = bp.ex_jalr ? {bp.ex_alu_result[31:1], 1'b0} : pc_imm;
    bp.pc_four = ex_pc32 + 32'd4;
    bp.pc_imm = pc_imm;
    bp.br_pc = br_pc;
    bp.pc_sel = taken && bp.ex_valid;
    bp.mispredict = bp.ex_valid && (taken != bp.ex_pred_taken || (taken && br_pc != bp.ex_pred_target));
    bp.redirect_pc = taken ? br_pc : bp.pc_four;
  end
  // fetch lookup; counter at or above weakly-taken means its MSB is set
  always_comb begin
    hit_if = if_e.valid && if_e.tag == if_tag;
    bp.pred_taken = hit_if && (if_e.jump || if_e.ctr >= ctr_weak_t(CTR_W));
    bp.pred_target = bp.pred_taken ? if_e.target : '0;
  end
  // training: update a hit in place, allocate on a taken miss
  always_comb begin
    hit_ex = ex_e.valid && ex_e.tag == ex_tag;
    train = bp.ex_valid && (bp.ex_branch || bp.ex_jal || bp.ex_jalr);
    we = train && (hit_ex || taken);
    wd.valid = 1'b1;
    wd.tag = ex_tag;
    wd.target = taken ? br_pc : ex_e.target;
    wd.jump = hit_ex ? ex_e.jump : (bp.ex_jal || bp.ex_jalr);
    wd.ctr = !hit_ex ? ctr_weak_t(CTR_W) : !bp.ex_branch ? ex_e.ctr :
             taken ? sat_inc(ex_e.ctr, CTR_W) : sat_dec(ex_e.ctr);
  end
  // saturating resolved-instruction and mispredict statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      bp.br_count <= '0;
      bp.mp_count <= '0;
    end else begin
      bp.br_count <= bp.br_count + {15'd0, train && bp.br_count != '1};
      bp.mp_count <= bp.mp_count + {15'd0, bp.mispredict && bp.mp_count != '1};
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and randomized checks against a BTB reference model
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  bit mv [16];
  int mtag [16];
  logic [31:0] mt [16];
  bit mj [16];
  int mc [16];
  int bc, mpc;
  always #5 clk = ~clk;
  branch_predict_unit_if #(.PC_W(9)) bp();
  branch_predict_unit #(.PC_W(9), .ENTRIES(16), .CTR_W(2)) dut (.clk(clk), .reset(reset), .bp(bp));

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0;
      mc[i] = 1;
    end
    bc = 0;
    mpc = 0;
  endfunction

  function automatic bit m_hit(input logic [8:0] pc);
    return mv[int'(pc[5:2])] && mtag[int'(pc[5:2])] == int'(pc[8:6]);
  endfunction

  function automatic bit m_pred(input logic [8:0] pc);
    return m_hit(pc) && (mj[int'(pc[5:2])] || mc[int'(pc[5:2])] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [8:0] pc);
    return m_pred(pc) ? mt[int'(pc[5:2])] : 32'd0;
  endfunction

  task automatic step(input logic [8:0] ipc, input bit v, input logic [8:0] pc, input logic [31:0] imm,
                      input int cls, input logic [31:0] alu, input bit pt, input logic [31:0] ptg, input bit rst);
    logic [31:0] p32, four, pimm, brpc, red, etg;
    bit tk, mp, ep;
    int j;
    @(negedge clk);
    reset = rst;
    bp.if_pc = ipc;
    bp.ex_valid = v;
    bp.ex_pc = pc;
    bp.ex_imm = imm;
    bp.ex_branch = cls == 1;
    bp.ex_jal = cls == 2;
    bp.ex_jalr = cls == 3;
    bp.ex_alu_result = alu;
    bp.ex_pred_taken = pt;
    bp.ex_pred_target = ptg;
    #1;
    p32 = {23'd0, pc};
    four = p32 + 32'd4;
    pimm = p32 + (imm << 1);
    tk = (cls == 1 && alu == 32'd1) || cls >= 2;
    brpc = cls == 3 ? (alu & ~32'd1) : pimm;
    mp = v && (tk != pt || (tk && brpc != ptg));
    red = tk ? brpc : four;
    ep = m_pred(ipc);
    etg = m_target(ipc);
    checks++; if (bp.pred_taken !== ep) begin failures++; $display("FAIL pred_taken pc=%h got=%b exp=%b", ipc, bp.pred_taken, ep); end
    checks++; if (bp.pred_target !== etg) begin failures++; $display("FAIL pred_target pc=%h got=%h exp=%h", ipc, bp.pred_target, etg); end
    checks++; if (bp.pc_four !== four) begin failures++; $display("FAIL pc_four got=%h exp=%h", bp.pc_four, four); end
    checks++; if (bp.pc_imm !== pimm) begin failures++; $display("FAIL pc_imm got=%h exp=%h", bp.pc_imm, pimm); end
    checks++; if (bp.br_pc !== brpc) begin failures++; $display("FAIL br_pc got=%h exp=%h", bp.br_pc, brpc); end
    checks++; if (bp.pc_sel !== (tk && v)) begin failures++; $display("FAIL pc_sel got=%b exp=%b", bp.pc_sel, tk && v); end
    checks++; if (bp.mispredict !== mp) begin failures++; $display("FAIL mispredict got=%b exp=%b", bp.mispredict, mp); end
    checks++; if (bp.redirect_pc !== red) begin failures++; $display("FAIL redirect_pc got=%h exp=%h", bp.redirect_pc, red); end
    checks++; if (bp.br_count !== 16'(bc)) begin failures++; $display("FAIL br_count got=%0d exp=%0d", bp.br_count, bc); end
    checks++; if (bp.mp_count !== 16'(mpc)) begin failures++; $display("FAIL mp_count got=%0d exp=%0d", bp.mp_count, mpc); end
    if (rst) begin
      model_reset();
    end else begin
      if (mp && mpc < 65535) mpc++;
      if (v && cls != 0) begin
        if (bc < 65535) bc++;
        j = int'(pc[5:2]);
        if (m_hit(pc)) begin
          if (tk) mt[j] = brpc;
          if (cls == 1) mc[j] = tk ? (mc[j] < 3 ? mc[j] + 1 : 3) : (mc[j] > 0 ? mc[j] - 1 : 0);
        end else if (tk) begin
          mv[j] = 1;
          mtag[j] = int'(pc[8:6]);
          mt[j] = brpc;
          mj[j] = cls >= 2;
          mc[j] = 2;
        end
      end
    end
  endtask

  task automatic test_reset();
    step(9'h000, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    checks++; if (bp.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", bp.pred_taken); end
    step(9'h010, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    step(9'h1fc, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    checks++; if (bp.br_count !== 16'd0) begin failures++; $display("FAIL reset_br_count got=%0d exp=0", bp.br_count); end
  endtask

  task automatic test_branch();
    step(9'h010, 1, 9'h010, 32'd8, 1, 32'd1, 0, 0, 0);
    checks++; if (bp.br_pc !== 32'h20) begin failures++; $display("FAIL br_target got=%h exp=00000020", bp.br_pc); end
    checks++; if (bp.mispredict !== 1'b1) begin failures++; $display("FAIL br_mispredict got=%b exp=1", bp.mispredict); end
    checks++; if (bp.redirect_pc !== 32'h20) begin failures++; $display("FAIL br_redirect got=%h exp=00000020", bp.redirect_pc); end
    step(9'h010, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    checks++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h20) begin failures++;
      $display("FAIL br_learned got=%b/%h exp=1/00000020", bp.pred_taken, bp.pred_target); end
  endtask

  task automatic test_counter();
    step(9'h010, 1, 9'h010, 32'd8, 1, 32'd0, 1, 32'h20, 0);
    checks++; if (bp.pred_taken !== 1'b1) begin failures++; $display("FAIL ctr_rbw got=%b exp=1", bp.pred_taken); end
    step(9'h010, 1, 9'h010, 32'd8, 1, 32'd0, 0, 0, 0);
    checks++; if (bp.pred_taken !== 1'b0) begin failures++; $display("FAIL ctr_drop got=%b exp=0", bp.pred_taken); end
    step(9'h010, 1, 9'h010, 32'd8, 1, 32'd0, 0, 0, 0);
    step(9'h010, 1, 9'h010, 32'd8, 1, 32'd1, 0, 0, 0);
    step(9'h010, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    checks++; if (bp.pred_taken !== 1'b0) begin failures++; $display("FAIL ctr_sat_low got=%b exp=0", bp.pred_taken); end
  endtask

  task automatic test_jalr();
    step(9'h100, 1, 9'h100, 32'd0, 3, 32'h135, 0, 0, 0);
    checks++; if (bp.br_pc !== 32'h134 || bp.pc_sel !== 1'b1) begin failures++;
      $display("FAIL jalr_target got=%h/%b exp=00000134/1", bp.br_pc, bp.pc_sel); end
    step(9'h100, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    checks++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h134) begin failures++;
      $display("FAIL jalr_pred got=%b/%h exp=1/00000134", bp.pred_taken, bp.pred_target); end
  endtask

  task automatic test_alias();
    step(9'h010, 1, 9'h010, 32'd8, 1, 32'd1, 0, 0, 0);
    step(9'h050, 1, 9'h050, 32'd4, 1, 32'd1, 0, 0, 0);
    step(9'h010, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    checks++; if (bp.pred_taken !== 1'b0) begin failures++; $display("FAIL alias_evict got=%b exp=0", bp.pred_taken); end
    step(9'h050, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    checks++; if (bp.pred_target !== 32'h58) begin failures++; $display("FAIL alias_new got=%h exp=00000058", bp.pred_target); end
  endtask

  task automatic test_reset_mid();
    step(9'h080, 1, 9'h080, 32'd2, 1, 32'd1, 0, 0, 1);
    checks++; if (bp.mispredict !== 1'b1) begin failures++; $display("FAIL rst_comb got=%b exp=1", bp.mispredict); end
    step(9'h080, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    checks++; if (bp.pred_taken !== 1'b0 || bp.mp_count !== 16'd0) begin failures++;
      $display("FAIL rst_mid got=%b/%0d exp=0/0", bp.pred_taken, bp.mp_count); end
    step(9'h050, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    checks++; if (bp.pred_taken !== 1'b0) begin failures++; $display("FAIL rst_cleared got=%b exp=0", bp.pred_taken); end
  endtask

  task automatic test_random();
    logic [8:0] pc, ipc;
    logic [31:0] imm, alu, r;
    int cls;
    bit pt;
    logic [31:0] ptg;
    for (int n = 0; n < 600; n++) begin
      pc = 9'(($urandom_range(0, 7) << 6) | ($urandom_range(0, 7) << 2));
      ipc = $urandom_range(0, 1) ? pc : 9'(($urandom_range(0, 7) << 6) | ($urandom_range(0, 7) << 2));
      r = $urandom;
      imm = $urandom_range(0, 3) != 0 ? {{26{r[5]}}, r[5:0]} : r;
      cls = $urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 3);
      alu = cls == 3 ? $urandom : 32'($urandom_range(0, 2));
      pt = $urandom_range(0, 3) != 0 ? m_pred(pc) : 1'($urandom_range(0, 1));
      ptg = $urandom_range(0, 3) != 0 ? m_target(pc) : $urandom;
      step(ipc, $urandom_range(0, 9) != 0, pc, imm, cls, alu, pt, ptg, $urandom_range(0, 59) == 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bp.if_pc = '0;
    bp.ex_valid = 1'b0;
    bp.ex_pc = '0;
    bp.ex_imm = '0;
    bp.ex_branch = 1'b0;
    bp.ex_jal = 1'b0;
    bp.ex_jalr = 1'b0;
    bp.ex_alu_result = '0;
    bp.ex_pred_taken = 1'b0;
    bp.ex_pred_target = '0;
    for (int i = 0; i < 16; i++) begin
      mtag[i] = 0;
      mt[i] = '0;
      mj[i] = 0;
    end
    model_reset();
    @(posedge clk);
    test_reset();
    test_branch();
    test_counter();
    test_jalr();
    test_alias();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
